// File: rtl/port_seq_ctrl.sv
// Pattern sequencer: plays a (pattern, duration) step table onto port_o with looping and
// optional end-of-step capture of port_i (enabled by defining PORT_SEQ_CAPTURE_EN).
module port_seq_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DUR_W  = 8,
  parameter int unsigned LOOP_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [WIDTH+DUR_W-1:0] wr_data_i,
  output logic                   wr_err_o,
  input  logic [AW:0]            num_steps_i,
  input  logic [LOOP_W-1:0]      loops_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [WIDTH-1:0]       port_i,
  output logic [WIDTH-1:0]       port_o,
  output logic [WIDTH-1:0]       cap_o,
  output logic                   cap_valid_o,
  output logic [AW-1:0]          step_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_pat [DEPTH];
  logic [DUR_W-1:0]   r_dur [DEPTH];
  logic [WIDTH-1:0]   r_port;
  logic [AW-1:0]      r_step;
  logic [AW-1:0]      r_last;
  logic [DUR_W-1:0]   r_timer;
  logic [LOOP_W-1:0]  r_loops;
  logic               r_busy;
  logic               r_done;
  logic               r_wr_err;

  logic [AW-1:0]      w_last;
  logic [AW-1:0]      w_next_step;
  logic               w_expire;

  // Index of the final step, with the requested count clamped to the table size.
  assign w_last      = (num_steps_i > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1)
                                                      : AW'(num_steps_i - (AW+1)'(1));
  assign w_next_step = r_step + AW'(1);
  assign w_expire    = (r_state == StHold) && !stop_i && (r_timer == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pat[i] <= '0;
        r_dur[i] <= '0;
      end
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en_i && (r_state != StIdle);
      if (wr_en_i && (r_state == StIdle)) begin
        r_pat[wr_addr_i] <= wr_data_i[WIDTH-1:0];
        r_dur[wr_addr_i] <= wr_data_i[WIDTH +: DUR_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_port  <= '0;
      r_step  <= '0;
      r_last  <= '0;
      r_timer <= '0;
      r_loops <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_i && (num_steps_i != '0)) begin
            r_state <= StHold;
            r_busy  <= 1'b1;
            r_last  <= w_last;
            r_loops <= loops_i;
            r_step  <= '0;
            r_port  <= r_pat[0];
            r_timer <= r_dur[0];
          end
        end
        StHold: begin
          if (stop_i) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_port  <= '0;
            r_step  <= '0;
          end else if (r_timer != '0) begin
            r_timer <= r_timer - DUR_W'(1);
          end else if (r_step != r_last) begin
            r_step  <= w_next_step;
            r_port  <= r_pat[w_next_step];
            r_timer <= r_dur[w_next_step];
          end else if (r_loops == LOOP_W'(1)) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else begin
            // A zero loop count never reaches one, so the table repeats until stopped.
            if (r_loops != '0) begin
              r_loops <= r_loops - LOOP_W'(1);
            end
            r_step  <= '0;
            r_port  <= r_pat[0];
            r_timer <= r_dur[0];
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          if (stop_i) begin
            r_port <= '0;
            r_step <= '0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PORT_SEQ_CAPTURE_EN
  logic [WIDTH-1:0] r_cap;
  logic             r_cap_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cap       <= '0;
      r_cap_valid <= 1'b0;
    end else begin
      r_cap_valid <= w_expire;
      if (w_expire) begin
        r_cap <= port_i;
      end
    end
  end

  assign cap_o       = r_cap;
  assign cap_valid_o = r_cap_valid;
`else
  logic [WIDTH-1:0] w_unused_port;
  assign w_unused_port = port_i;
  assign cap_o         = '0;
  assign cap_valid_o   = 1'b0;
`endif

  assign port_o   = r_port;
  assign step_o   = r_step;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign wr_err_o = r_wr_err;

endmodule
